rc4_ksa_engine: RTL and testbench

RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

---
 rtl/rc4_ksa_engine_if.sv | 25 ++
 rtl/rc4_ksa_engine.sv | 140 ++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_ksa_engine_if.sv
// Host/RAM bus of the RC4 key-schedule engine: run control, key, and the S-RAM port.
interface rc4_ksa_engine_if #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic                   mode;
  logic [KEY_BYTES*8-1:0] secret_key;
  logic [ADDR_W-1:0]      q;
  logic [ADDR_W-1:0]      address;
  logic [ADDR_W-1:0]      data;
  logic                   wren;
  logic                   busy;
  logic                   finish;

  modport master (
    output start, mode, secret_key, q,
    input  address, data, wren, busy, finish
  );

  modport slave (
    input  start, mode, secret_key, q,
    output address, data, wren, busy, finish
  );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling (KSA) sequencer driving an external S-RAM with RD_LAT read latency.
// One iteration takes 2*RD_LAT+5 cycles; optional N-cycle identity fill precedes the scramble.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 2
) (
  input  logic            clock,
  input  logic            reset,
  rc4_ksa_engine_if.slave bus
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST    = '1;
  localparam logic [KW-1:0]     K_LAST    = KW'(KEY_BYTES - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] RD_I   = 3'd2;
  localparam logic [2:0] CALC_J = 3'd3;
  localparam logic [2:0] RD_J   = 3'd4;
  localparam logic [2:0] WR_I   = 3'd5;
  localparam logic [2:0] WR_J   = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0]             state;
  logic [ADDR_W-1:0]      i;
  logic [ADDR_W-1:0]      j;
  logic [ADDR_W-1:0]      si;
  logic [ADDR_W-1:0]      sj;
  logic [KW-1:0]          k;
  logic [1:0]             cnt;
  logic [KEY_BYTES*8-1:0] key;
  logic [7:0]             key_arr [KEY_BYTES];
  logic [7:0]             key_byte;
  logic [ADDR_W-1:0]      address;
  logic [ADDR_W-1:0]      data;
  logic                   wren;

  // Byte 0 of the key sits in the most significant byte.
  always_comb begin
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_arr[b] = key[8*(KEY_BYTES-1-b) +: 8];
    end
    key_byte = key_arr[k];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      cnt   <= '0;
      key   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key   <= bus.secret_key;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            cnt   <= '0;
            state <= bus.mode ? INIT : RD_I;
          end
        end
        INIT: begin
          i <= i + 1'b1;
          if (i == I_LAST) state <= RD_I;
        end
        RD_I: begin
          if (cnt == WAIT_LAST) begin
            si    <= bus.q;
            cnt   <= '0;
            state <= CALC_J;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CALC_J: begin
          j     <= j + si + key_byte[ADDR_W-1:0];
          k     <= (k == K_LAST) ? '0 : k + 1'b1;
          state <= RD_J;
        end
        RD_J: begin
          if (cnt == WAIT_LAST) begin
            sj    <= bus.q;
            cnt   <= '0;
            state <= WR_I;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_I: state <= WR_J;
        WR_J: begin
          i     <= i + 1'b1;
          state <= (i == I_LAST) ? DONE : RD_I;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // When i==j the WR_J write lands last and restores si, leaving the entry unchanged.
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    case (state)
      INIT: begin
        address = i;
        data    = i;
        wren    = 1'b1;
      end
      RD_I: address = i;
      RD_J: address = j;
      WR_I: begin
        address = i;
        data    = sj;
        wren    = 1'b1;
      end
      WR_J: begin
        address = j;
        data    = si;
        wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.address = address;
  assign bus.data    = data;
  assign bus.wren    = wren;
  assign bus.busy    = (state != IDLE) && (state != DONE);
  assign bus.finish  = (state == DONE);
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Four engine instances (small, default, RD_LAT=1, RD_LAT=3) against latency RAM models and a software KSA.
module tb_rc4_ksa_engine;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic         start_s [4];
  logic         mode_s  [4];
  logic [127:0] key_s   [4];
  wire  [7:0]   addr_w  [4];
  wire  [7:0]   data_w  [4];
  wire          wren_w  [4];
  wire          busy_w  [4];
  wire          fin_w   [4];

  logic [7:0] mem  [4][256];
  logic [7:0] pipe [4][3];
  logic [7:0] cap_a [4] = '{default: 8'd0};
  logic [7:0] cap_d [4] = '{default: 8'd0};
  logic       cap_w [4] = '{default: 1'b0};
  int         load_u  = 0;
  logic       load_go = 1'b0;

  function automatic int n_of(input int u);
    return (u == 0) ? 16 : 256;
  endfunction
  function automatic int kb_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 3 : 5);
  endfunction
  function automatic int rl_of(input int u);
    return (u == 2) ? 1 : ((u == 3) ? 3 : 2);
  endfunction

  generate
    for (genvar g = 0; g < 4; g++) begin : g_u
      localparam int AW = (g == 0) ? 4 : 8;
      localparam int KB = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
      localparam int RL = (g == 2) ? 1 : ((g == 3) ? 3 : 2);
      rc4_ksa_engine_if #(.ADDR_W(AW), .KEY_BYTES(KB)) bus ();
      rc4_ksa_engine #(.ADDR_W(AW), .KEY_BYTES(KB), .RD_LAT(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
      );
      assign bus.start      = start_s[g];
      assign bus.mode       = mode_s[g];
      assign bus.secret_key = key_s[g][KB*8-1:0];
      assign bus.q          = pipe[g][RL-1][AW-1:0];
      assign addr_w[g]      = 8'(bus.address);
      assign data_w[g]      = 8'(bus.data);
      assign wren_w[g]      = bus.wren;
      assign busy_w[g]      = bus.busy;
      assign fin_w[g]       = bus.finish;
    end
  endgenerate

  // RAM: requests captured mid-cycle, applied at the edge; reads delayed through a 3-deep pipe.
  always @(posedge clock) begin
    for (int u = 0; u < 4; u++) begin
      if (cap_w[u]) mem[u][cap_a[u]] <= cap_d[u];
      pipe[u][0] <= mem[u][cap_a[u]];
      pipe[u][1] <= pipe[u][0];
      pipe[u][2] <= pipe[u][1];
    end
    if (load_go)
      for (int a = 0; a < 256; a++) mem[load_u][a] <= 8'(n_of(load_u) - 1 - a);
  end

  int   cyc = 0, mon_u = 1, busy_cnt = 0, fin_cnt = 0, rise_cnt = 0, busy_first = 0;
  logic busy_prev = 1'b0;
  int   wr_t[$];
  int   wr_a[$];
  int   wr_d[$];

  always @(negedge clock) begin
    cyc++;
    for (int u = 0; u < 4; u++) begin
      cap_a[u] = addr_w[u];
      cap_d[u] = data_w[u];
      cap_w[u] = wren_w[u];
    end
    if (busy_w[mon_u] === 1'b1) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_cnt++;
      if (!busy_prev) rise_cnt++;
    end
    busy_prev = (busy_w[mon_u] === 1'b1);
    if (fin_w[mon_u] === 1'b1) fin_cnt++;
    if (wren_w[mon_u] === 1'b1) begin
      wr_t.push_back(cyc);
      wr_a.push_back(int'(addr_w[mon_u]));
      wr_d.push_back(int'(data_w[mon_u]));
    end
  end

  int ref_s [256];

  function automatic int key_byte(input logic [127:0] key, input int kb, input int k);
    logic [127:0] sh;
    sh = key >> (8 * (kb - 1 - k));
    return int'(sh[7:0]);
  endfunction

  task automatic build_model(input int u, input logic md, input logic [127:0] key);
    int n = n_of(u);
    int kb = kb_of(u);
    int j = 0;
    int t;
    for (int x = 0; x < n; x++) ref_s[x] = md ? x : int'(mem[u][x]);
    for (int x = 0; x < n; x++) begin
      j = (j + ref_s[x] + key_byte(key, kb, x % kb) % n) % n;
      t = ref_s[x];
      ref_s[x] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  function automatic int ram_diff(input int u);
    int d = 0;
    for (int x = 0; x < n_of(u); x++)
      if (mem[u][x] !== 8'(ref_s[x])) d++;
    return d;
  endfunction

  task automatic preload(input int u);
    @(negedge clock);
    load_u  = u;
    load_go = 1'b1;
    @(negedge clock);
    load_go = 1'b0;
  endtask

  bit done_clean;

  task automatic do_run(input int u, input logic md, input logic [127:0] key, input bit toggle);
    bit seen = 1'b0;
    @(negedge clock);
    mon_u = u; busy_cnt = 0; fin_cnt = 0; rise_cnt = 0; busy_prev = 1'b0;
    wr_t.delete(); wr_a.delete(); wr_d.delete();
    mode_s[u] = md; key_s[u] = key; start_s[u] = 1'b1;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clock);
      if (toggle) key_s[u] = {$urandom, $urandom, $urandom, $urandom};
      else start_s[u] = 1'b0;
      if (fin_w[u] === 1'b1) begin
        seen = 1'b1;
        done_clean = (busy_w[u] === 1'b0) && (wren_w[u] === 1'b0) &&
                     (addr_w[u] === 8'd0) && (data_w[u] === 8'd0);
      end
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL run_done unit=%0d: finish seen=0, expected 1", u); end
    @(negedge clock);
  endtask

  task automatic test_reset();
    start_s[1] = 1'b1; mode_s[1] = 1'b1;
    repeat (2) @(negedge clock);
    for (int u = 0; u < 4; u++) begin
      n_tests++;
      if ({busy_w[u], wren_w[u], fin_w[u], addr_w[u], data_w[u]} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_outputs unit=%0d: got %h, expected 0", u,
                 {busy_w[u], wren_w[u], fin_w[u], addr_w[u], data_w[u]});
      end
    end
    start_s[1] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_small();
    int bad = 0;
    build_model(0, 1'b1, 128'h0);
    do_run(0, 1'b1, 128'h0, 1'b0);
    n_tests++;
    if (wr_t.size() != 48) begin n_fail++; $display("FAIL small_writes: got %0d, expected 48", wr_t.size()); end
    for (int m = 0; m < 16; m++)
      if (wr_a[m] != m || wr_d[m] != m || wr_t[m] != busy_first + m) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL small_init_fill: %0d bad entries, expected 0", bad); end
    n_tests++;
    if (wr_a[16] != 0 || wr_a[17] != 0 || wr_d[16] != 0 || wr_d[17] != 0) begin
      n_fail++;
      $display("FAIL small_iter0: addr %0d/%0d data %0d/%0d, expected all 0", wr_a[16], wr_a[17], wr_d[16], wr_d[17]);
    end
    n_tests++;
    if (busy_cnt != 160) begin n_fail++; $display("FAIL small_busy: got %0d, expected 160", busy_cnt); end
    n_tests++;
    if (fin_cnt != 1) begin n_fail++; $display("FAIL small_finish: got %0d, expected 1", fin_cnt); end
    n_tests++;
    if (!done_clean) begin n_fail++; $display("FAIL small_done_outputs: got dirty, expected busy/wren/addr/data 0"); end
    n_tests++;
    if (ram_diff(0) != 0) begin n_fail++; $display("FAIL small_ram: %0d mismatches, expected 0", ram_diff(0)); end
  endtask

  task automatic test_default();
    build_model(1, 1'b1, 128'h00033C);
    do_run(1, 1'b1, 128'h00033C, 1'b0);
    n_tests++;
    if (ram_diff(1) != 0) begin n_fail++; $display("FAIL default_ram: %0d mismatches, expected 0", ram_diff(1)); end
    n_tests++;
    if (busy_cnt != 2560) begin n_fail++; $display("FAIL default_busy: got %0d, expected 2560", busy_cnt); end
    n_tests++;
    if (fin_cnt != 1 || wr_t.size() != 768) begin
      n_fail++; $display("FAIL default_counts: finish %0d writes %0d, expected 1 and 768", fin_cnt, wr_t.size());
    end
  endtask

  task automatic test_scramble_only();
    logic [127:0] key;
    key = 128'($urandom_range(0, 32'hFF_FFFF));
    preload(1);
    build_model(1, 1'b0, key);
    do_run(1, 1'b0, key, 1'b0);
    n_tests++;
    if (wr_t.size() != 512) begin n_fail++; $display("FAIL scr_writes: got %0d, expected 512", wr_t.size()); end
    n_tests++;
    if (wr_t[0] - busy_first != 7) begin n_fail++; $display("FAIL scr_first_write: offset %0d, expected 7", wr_t[0] - busy_first); end
    n_tests++;
    if (ram_diff(1) != 0) begin n_fail++; $display("FAIL scr_ram: %0d mismatches, expected 0", ram_diff(1)); end
    n_tests++;
    if (busy_cnt != 2304 || fin_cnt != 1) begin
      n_fail++; $display("FAIL scr_busy: busy %0d finish %0d, expected 2304 and 1", busy_cnt, fin_cnt);
    end
  endtask

  task automatic test_key_toggle();
    build_model(1, 1'b1, 128'h00033C);
    do_run(1, 1'b1, 128'h00033C, 1'b1);
    n_tests++;
    if (ram_diff(1) != 0) begin n_fail++; $display("FAIL tog_ram: %0d mismatches, expected 0", ram_diff(1)); end
    n_tests++;
    if (rise_cnt != 1 || busy_cnt != 2560) begin
      n_fail++; $display("FAIL tog_restart: rises %0d busy %0d, expected 1 and 2560", rise_cnt, busy_cnt);
    end
    n_tests++;
    if (busy_w[1] !== 1'b0) begin n_fail++; $display("FAIL tog_done_ignores_start: busy %b, expected 0", busy_w[1]); end
    @(negedge clock);
    n_tests++;
    if (busy_w[1] !== 1'b1) begin n_fail++; $display("FAIL tog_idle_accepts_start: busy %b, expected 1", busy_w[1]); end
    start_s[1] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [127:0] key;
    int idx = 0;
    bit hit = 1'b0;
    int tgt = 256 + 100 * 9 + 5;
    key = 128'($urandom_range(0, 32'hFF_FFFF));
    @(negedge clock);
    mon_u = 1; busy_cnt = 0; fin_cnt = 0;
    mode_s[1] = 1'b1; key_s[1] = key; start_s[1] = 1'b1;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clock);
      start_s[1] = 1'b0;
      if (busy_w[1] === 1'b1) begin
        if (idx == tgt) hit = 1'b1;
        else idx++;
      end
    end
    n_tests++;
    if (!hit || wren_w[1] !== 1'b0) begin
      n_fail++; $display("FAIL abort_reach_rd_j: reached %0d wren %b, expected 1 and 0", hit, wren_w[1]);
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({busy_w[1], wren_w[1], fin_w[1], addr_w[1]} !== 11'd0) begin
      n_fail++; $display("FAIL abort_outputs: got %h, expected 0", {busy_w[1], wren_w[1], fin_w[1], addr_w[1]});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (fin_cnt != 0) begin n_fail++; $display("FAIL abort_no_finish: got %0d, expected 0", fin_cnt); end
    key = 128'($urandom_range(0, 32'hFF_FFFF));
    build_model(1, 1'b1, key);
    do_run(1, 1'b1, key, 1'b0);
    n_tests++;
    if (ram_diff(1) != 0 || busy_cnt != 2560 || fin_cnt != 1) begin
      n_fail++;
      $display("FAIL abort_rerun: ram diff %0d busy %0d finish %0d, expected 0 2560 1", ram_diff(1), busy_cnt, fin_cnt);
    end
  endtask

  task automatic test_lat_sweep();
    for (int u = 2; u < 4; u++) begin
      logic [127:0] key;
      int rl = rl_of(u);
      int per = 2 * rl + 5;
      int bad_p = 0;
      int bad_k = 0;
      int jp = 0;
      if (u == 2) key = 128'hA1B2C3D4E5;
      else begin
        key = {$urandom, $urandom, $urandom, $urandom};
        key = key & 128'hFF_FFFF_FFFF;
      end
      build_model(u, 1'b1, key);
      do_run(u, 1'b1, key, 1'b0);
      n_tests++;
      if (wr_t.size() != 768 || ram_diff(u) != 0) begin
        n_fail++; $display("FAIL sweep_ram rl=%0d: writes %0d diff %0d, expected 768 and 0", rl, wr_t.size(), ram_diff(u));
      end
      n_tests++;
      if (busy_cnt != 256 + 256 * per || fin_cnt != 1) begin
        n_fail++; $display("FAIL sweep_busy rl=%0d: busy %0d finish %0d, expected %0d and 1", rl, busy_cnt, fin_cnt, 256 + 256 * per);
      end
      n_tests++;
      if (wr_t[256] - busy_first != 256 + 2 * rl + 3) begin
        n_fail++; $display("FAIL sweep_first_iter rl=%0d: offset %0d, expected %0d", rl, wr_t[256] - busy_first, 256 + 2 * rl + 3);
      end
      for (int m = 1; m < 256; m++)
        if (wr_t[256 + 2*m] - wr_t[254 + 2*m] != per || wr_a[256 + 2*m] != m) bad_p++;
      n_tests++;
      if (bad_p != 0) begin n_fail++; $display("FAIL sweep_period rl=%0d: %0d bad iterations, expected 0 (period %0d)", rl, bad_p, per); end
      for (int m = 0; m < 256; m++) begin
        int jn = wr_a[257 + 2*m];
        if (((jn - jp - wr_d[257 + 2*m]) & 255) != key_byte(key, 5, m % 5)) bad_k++;
        jp = jn;
      end
      n_tests++;
      if (bad_k != 0) begin n_fail++; $display("FAIL sweep_key_order rl=%0d: %0d bad iterations, expected 0", rl, bad_k); end
    end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      start_s[u] = 1'b0;
      mode_s[u]  = 1'b0;
      key_s[u]   = '0;
    end
    test_reset();
    test_small();
    test_default();
    test_scramble_only();
    test_key_toggle();
    test_reset_abort();
    test_lat_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected all scenarios to complete");
    $fatal(1, "watchdog expired");
  end
endmodule
